// File: rtl/ivl_uvm_ovl_pkg.sv
// Shared definitions for the OVL cycle-sequence stimulus generator:
// FSM state encoding, minimum hold constant and the thermometer helper.
package ivl_uvm_ovl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // A hold request of 0 is promoted to this many cycles.
    localparam int unsigned MIN_HOLD = 1;

    // Widest pattern the helper can build; callers size-cast to their width.
    localparam int unsigned THERM_MAX_W = 64;

    // Returns an n-bit vector (zero-extended to THERM_MAX_W) with the top k bits set.
    function automatic logic [THERM_MAX_W-1:0] therm(input int unsigned k, input int unsigned n);
        logic [THERM_MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < THERM_MAX_W; i++) begin
            if ((i < n) && (i + k >= n)) begin
                v = v | (THERM_MAX_W'(1) << i);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/ivl_uvm_ovl_cycle_seq_gen.sv
// Stimulus generator for the OVL cycle-sequence checker: walks event_sequence
// through a thermometer fill from the MSB down, holding each pattern for a
// programmable number of clocks, with optional corruption of one step.
module ivl_uvm_ovl_cycle_seq_gen
    import ivl_uvm_ovl_pkg::*;
#(
    parameter int unsigned NUM_CKS = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned IDX_W   = $clog2(NUM_CKS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   hold_cks,
    input  logic               err_en,
    input  logic [IDX_W-1:0]   err_step,
    output logic [NUM_CKS-1:0] event_sequence,
    output logic [IDX_W-1:0]   step,
    output logic               busy,
    output logic               done
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_hold_m1;
    logic               r_err_act;
    logic [IDX_W-1:0]   r_err_step;
    logic [IDX_W-1:0]   r_step;
    logic [NUM_CKS-1:0] r_seq;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [CNT_W-1:0]   w_hold_m1_nx;
    logic               w_err_act_nx;
    logic [IDX_W-1:0]   w_err_step_nx;
    logic [IDX_W-1:0]   w_step_nx;
    logic [NUM_CKS-1:0] w_seq_nx;
    logic               w_busy_nx;
    logic               w_done_nx;

    logic [CNT_W-1:0]   w_hold_m1_in;
    logic               w_err_act_in;
    logic [IDX_W-1:0]   w_step_inc;
    logic [NUM_CKS-1:0] w_pat_inc;

    // Hold is stored as H-1 so the counter reloads and counts down to zero.
    assign w_hold_m1_in = (hold_cks < CNT_W'(MIN_HOLD)) ? '0 : (hold_cks - CNT_W'(MIN_HOLD));
    // Out-of-range err_step values are folded into a single "inject" flag at latch time.
    assign w_err_act_in = err_en && (err_step != '0) && (err_step < IDX_W'(NUM_CKS));
    assign w_step_inc   = r_step + IDX_W'(1);

    // Pattern for the step about to begin: nominal thermometer, or the
    // previous step's pattern with bit 0 raised early when corrupted.
    always_comb begin
        w_pat_inc = NUM_CKS'(therm(32'(w_step_inc), NUM_CKS));
        if (r_err_act && (w_step_inc == r_err_step)) begin
            w_pat_inc = NUM_CKS'(therm(32'(w_step_inc) - 32'd1, NUM_CKS))
                      | {{(NUM_CKS-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_hold_m1_nx  = r_hold_m1;
        w_err_act_nx  = r_err_act;
        w_err_step_nx = r_err_step;
        w_step_nx     = r_step;
        w_seq_nx      = r_seq;
        w_busy_nx     = r_busy;
        w_done_nx     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nx    = RUN;
                    w_hold_m1_nx  = w_hold_m1_in;
                    w_err_act_nx  = w_err_act_in;
                    w_err_step_nx = err_step;
                    w_cnt_nx      = w_hold_m1_in;
                    w_step_nx     = '0;
                    w_seq_nx      = '0;
                    w_busy_nx     = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_cnt_nx = r_hold_m1;
                    if (r_step == IDX_W'(NUM_CKS)) begin
                        w_state_nx = DONE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_step_nx = w_step_inc;
                        w_seq_nx  = w_pat_inc;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hold_m1  <= '0;
            r_err_act  <= 1'b0;
            r_err_step <= '0;
            r_step     <= '0;
            r_seq      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_hold_m1  <= w_hold_m1_nx;
            r_err_act  <= w_err_act_nx;
            r_err_step <= w_err_step_nx;
            r_step     <= w_step_nx;
            r_seq      <= w_seq_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
        end
    end

    assign event_sequence = r_seq;
    assign step           = r_step;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
